// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one UART TX FIFO.
// Four requesters offer bytes. A grant locks the UART to one owner until
// that owner's last byte is accepted by the FIFO.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN. When defined, an owner that
// stops offering bytes for TIMEOUT consecutive locked cycles is forcibly released.
//
// Handshake: a byte moves only in a cycle where the arbiter is locked,
// req[owner]=1 and tx_full=0. In that cycle wr=1, and ack[owner] pulses in
// the same cycle. A requester holds req, last and its data byte stable until
// it sees its ack.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [31:0] data,
    output logic [3:0]  ack,
    input  logic        tx_full,
    output logic        wr,
    output logic [7:0]  wdata,
    output logic        gnt_valid,
    output logic [1:0]  gnt_id,
    output logic        timeout_err,
    output logic        state_dbg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] owner;
    logic [1:0] rr_ptr;
    logic [1:0] pick;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic       owner_req;
    logic       owner_last;
    logic [7:0] owner_byte;
    logic       byte_take;
    logic       release_lock;
    logic       timeout_hit;

    // TIMEOUT is legal in 1..65535. An out-of-range value leaves this marker
    // scope in the hierarchy, so it is easy to spot.
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_timeout_out_of_range
    end

    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign owner_byte = data[{owner, 3'b000} +: 8];

    // A byte is taken only while locked, with the owner offering a byte and
    // the FIFO able to accept it. A forced release or a reset blocks the byte.
    assign byte_take    = (state == ST_LOCK) & owner_req & ~tx_full & ~timeout_hit & ~rst;
    assign release_lock = (byte_take & owner_last) | timeout_hit;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = (state == ST_LOCK) && (idle_cnt == 16'(TIMEOUT));

    // Count locked cycles in which the owner offers nothing.
    // Clear the count in IDLE, so that each new lock starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == ST_IDLE || owner_req || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Search the requesters round-robin, starting with the one after the
    // last owner. The first requester found with req set is the new owner.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pick_idx = rr_ptr + 2'(k);
            if (!pick_found && req[pick_idx]) begin
                pick       = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping. The owner is latched when the lock is entered.
    // The round-robin pointer moves to the owner when the lock is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= 2'd0;
            rr_ptr <= 2'd3;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_LOCK) begin
                owner <= pick;
            end
            if (state == ST_LOCK && release_lock) begin
                rr_ptr <= owner;
            end
        end
    end

    // Next-state logic. In IDLE, lock when enabled and a request is present.
    // In LOCK, return to IDLE on an accepted last byte or on a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en && (req != 4'b0000)) state_nxt = ST_LOCK;
            ST_LOCK: if (release_lock)           state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. The byte path is combinational from the owner's inputs.
    // The grant outputs come from registered state.
    always_comb begin
        wr          = byte_take;
        ack         = byte_take ? (4'b0001 << owner) : 4'b0000;
        wdata       = (state == ST_LOCK) ? owner_byte : 8'h00;
        gnt_valid   = (state == ST_LOCK);
        gnt_id      = owner;
        timeout_err = timeout_hit & ~rst;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// When UART_TX_ARB_TIMEOUT_EN is defined, the forced-release case is exercised.
// Otherwise the bench checks that the lock is held.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        tx_full;
    logic        wr;
    logic [7:0]  wdata;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        timeout_err;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .last        (last),
        .data        (data),
        .ack         (ack),
        .tx_full     (tx_full),
        .wr          (wr),
        .wdata       (wdata),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. Checks run 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_id;
        logic [7:0] exp_byte;

        rst = 1'b1; en = 1'b0; req = 4'b0000; last = 4'b0000;
        data = 32'h0; tx_full = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wr", wr, 1'b0);
        chk("rst_wdata", wdata, 8'h00);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_gnt_valid", gnt_valid, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_gnt_id", gnt_id, 2'd0);

        // ---------- round robin, 1-byte packets from all four ----------
        en = 1'b1; req = 4'b1111; last = 4'b1111; data = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            exp_id   = 2'(i % 4);
            exp_byte = 8'(8'h11 * (exp_id + 1));
            #1;
            chk("rr_idle_gnt_valid", gnt_valid, 1'b0);
            chk("rr_idle_wr", wr, 1'b0);
            tick();
            #1;
            chk("rr_gnt_valid", gnt_valid, 1'b1);
            chk("rr_gnt_id", gnt_id, exp_id);
            chk("rr_wr", wr, 1'b1);
            chk("rr_wdata", wdata, exp_byte);
            chk("rr_ack", ack, 4'b0001 << exp_id);
            tick();
        end
        req = 4'b0000; last = 4'b0000;

        // ---------- 3-byte packet from requester 2, req[0] waiting ----------
        tick();
        req = 4'b0101; last = 4'b0000;
        data = 32'h00A10055;
        #1;
        chk("pkt_idle", gnt_valid, 1'b0);
        tick();
        #1;
        chk("pkt_gnt_id", gnt_id, 2'd2);
        chk("pkt_b1_wdata", wdata, 8'hA1);
        chk("pkt_b1_ack", ack, 4'b0100);
        tick();
        data[23:16] = 8'hA2;
        #1;
        chk("pkt_b2_wdata", wdata, 8'hA2);
        chk("pkt_b2_ack", ack, 4'b0100);
        tick();
        data[23:16] = 8'hA3; last = 4'b0101;
        #1;
        chk("pkt_b3_wdata", wdata, 8'hA3);
        chk("pkt_b3_ack", ack, 4'b0100);
        tick();
        #1;
        chk("pkt_release_gnt_valid", gnt_valid, 1'b0);
        chk("pkt_release_wr", wr, 1'b0);
        tick();
        #1;
        chk("pkt_next_gnt_id", gnt_id, 2'd0);
        chk("pkt_next_wdata", wdata, 8'h55);
        chk("pkt_next_ack", ack, 4'b0001);
        tick();
        req = 4'b0000; last = 4'b0000;

        // ---------- last byte stalled by tx_full ----------
        tick();
        req = 4'b0010; last = 4'b0010; data = 32'h00005A00; tx_full = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_wr", wr, 1'b0);
            chk("full_ack", ack, 4'b0000);
            chk("full_gnt_valid", gnt_valid, 1'b1);
            tick();
        end
        tx_full = 1'b0;
        #1;
        chk("full_drain_wr", wr, 1'b1);
        chk("full_drain_ack", ack, 4'b0010);
        chk("full_drain_wdata", wdata, 8'h5A);
        tick();
        req = 4'b0000; last = 4'b0000;
        #1;
        chk("full_release", gnt_valid, 1'b0);

        // ---------- en gating, and en falling mid-packet ----------
        tick();
        en = 1'b0; req = 4'b0010; last = 4'b0000; data = 32'h00006600;
        #1;
        chk("en_off_gnt", gnt_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("en_off_hold_gnt", gnt_valid, 1'b0);
            chk("en_off_hold_wr", wr, 1'b0);
        end
        tick();
        en = 1'b1;
        #1;
        chk("en_on_same_cycle", gnt_valid, 1'b0);
        tick();
        en = 1'b0;
        #1;
        chk("en_on_gnt_valid", gnt_valid, 1'b1);
        chk("en_on_gnt_id", gnt_id, 2'd1);
        chk("en_on_wdata", wdata, 8'h66);
        tick();
        last = 4'b0010;
        #1;
        chk("en_low_lock_wr", wr, 1'b1);
        chk("en_low_lock_gnt", gnt_valid, 1'b1);
        tick();
        req = 4'b0000; last = 4'b0000; en = 1'b1;
        #1;
        chk("en_low_release", gnt_valid, 1'b0);
        chk("gnt_id_held", gnt_id, 2'd1);

        // ---------- owner goes silent after one byte ----------
        tick();
        req = 4'b1000; data = 32'h77000000;
        tick();
        #1;
        chk("to_gnt_id", gnt_id, 2'd3);
        chk("to_b1_wr", wr, 1'b1);
        chk("to_b1_wdata", wdata, 8'h77);
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            req = 4'b0000;
            #1;
            chk("to_wait_err", timeout_err, 1'b0);
            chk("to_wait_gnt", gnt_valid, 1'b1);
            chk("to_wait_wr", wr, 1'b0);
        end
        tick();
        req = 4'b1000;
        #1;
        chk("to_fire_err", timeout_err, 1'b1);
        chk("to_fire_wr", wr, 1'b0);
        chk("to_fire_ack", ack, 4'b0000);
        tick();
        req = 4'b0000;
        #1;
        chk("to_after_gnt", gnt_valid, 1'b0);
        chk("to_after_err", timeout_err, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            req = 4'b0000;
            #1;
            chk("hold_err", timeout_err, 1'b0);
            chk("hold_gnt", gnt_valid, 1'b1);
            chk("hold_wr", wr, 1'b0);
        end
        tick();
        req = 4'b1000; last = 4'b1000;
        #1;
        chk("hold_last_wr", wr, 1'b1);
        chk("hold_last_ack", ack, 4'b1000);
        tick();
        req = 4'b0000; last = 4'b0000;
        #1;
        chk("hold_release", gnt_valid, 1'b0);
`endif

        // ---------- reset in the middle of a packet ----------
        tick();
        req = 4'b0100; last = 4'b0000; data = 32'h00880000;
        tick();
        #1;
        chk("mid_rst_b1_wr", wr, 1'b1);
        chk("mid_rst_b1_wdata", wdata, 8'h88);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0101; data = 32'h00880099;
        #1;
        chk("mid_rst_wr", wr, 1'b0);
        chk("mid_rst_ack", ack, 4'b0000);
        chk("mid_rst_gnt_valid", gnt_valid, 1'b0);
        chk("mid_rst_timeout_err", timeout_err, 1'b0);
        chk("mid_rst_gnt_id", gnt_id, 2'd0);
        tick();
        #1;
        chk("post_rst_gnt_valid", gnt_valid, 1'b1);
        chk("post_rst_gnt_id", gnt_id, 2'd0);
        chk("post_rst_wdata", wdata, 8'h99);
        tick();
        req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200: idle cycles tolerated while a packet is locked (valid 1..65535).
REQ-002 SHALL have clk  input  1: single clock; all logic on its rising edge.
REQ-003 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have en  input  1: when low, no new grant is issued; a locked packet still completes.
REQ-005 SHALL have req  input  4: requester i has a byte available.
REQ-006 SHALL have last  input  4: requester i's current byte ends its packet.
REQ-007 SHALL have data  input  32: byte of requester i on bits [8i+7:8i].
REQ-008 SHALL have ack  output  4: one-hot pulse, requester i's byte taken this cycle.
REQ-009 SHALL have tx_full  input  1: UART TX FIFO full flag.
REQ-010 SHALL have wr  output  1: write strobe to UART TX FIFO.
REQ-011 SHALL have wdata  output  8: byte to UART TX FIFO.
REQ-012 SHALL have gnt_valid  output  1: a requester currently holds the lock.
REQ-013 SHALL have gnt_id  output  2: index of the lock holder (held at last value when gnt_valid=0).
REQ-014 SHALL have timeout_err  output  1: one-cycle pulse on forced release.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, LOCK.
REQ-016 IDLE->LOCK SHALL occur when en=1 and req!=0; owner = first set req bit searching round-robin starting at (rr_ptr+1) mod 4.
REQ-017 On entering LOCK, gnt_valid SHALL rise and gnt_id SHALL equal the owner in the next cycle; no byte is written in the granting cycle.
REQ-018 In LOCK, wr SHALL be combinational: wr = req[owner] & ~tx_full; wdata = data[owner]; ack[owner] = wr; other ack bits 0.
REQ-019 wr SHALL never assert in IDLE or when tx_full=1.
REQ-020 An accepted byte with last[owner]=1 SHALL return FSM to IDLE next cycle and set rr_ptr = owner.
REQ-021 last[owner]=1 with tx_full=1 SHALL NOT release the lock; release occurs only when that byte is accepted.
REQ-022 req/last bits of non-owners SHALL be ignored while in LOCK.
REQ-023 Minimum packet spacing SHALL be one IDLE cycle between consecutive grants; throughput within a packet is one byte per cycle.
REQ-024 en falling during LOCK SHALL NOT affect the current packet.

Reset
REQ-025 With rst=1 at a clock edge: FSM=IDLE, rr_ptr=3 (requester 0 first), gnt_id=0, timeout counter=0.
REQ-026 Reset values of outputs: wr=0, wdata=0, ack=0, gnt_valid=0, timeout_err=0.
REQ-027 rst asserted mid-packet SHALL abandon the packet with no further wr or ack, and SHALL NOT pulse timeout_err.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN SHALL compile in the lock timeout.
REQ-029 With it defined, a 16-bit counter SHALL increment each LOCK cycle with req[owner]=0 and clear on req[owner]=1 or on entering LOCK.
REQ-030 With it defined, when the counter reaches TIMEOUT, FSM SHALL go to IDLE and rr_ptr SHALL equal owner, with timeout_err pulsed for that cycle and wr=0.
REQ-031 Without it, the counter SHALL be absent, timeout_err SHALL be tied 0, and the lock SHALL be held until an accepted last byte.

Verification
REQ-032 After reset, req=4'b1111, each requester sends a 1-byte packet (last=1), tx_full=0 -> grants 0,1,2,3,0 in order, one wr per grant.
REQ-033 Requester 2 sends 3-byte packet 0xA1,0xA2,0xA3 while req[0] is held high -> wdata A1,A2,A3 on consecutive cycles, ack=4'b0100 each; requester 0 granted only after release.
REQ-034 Owner holds last=1 and tx_full=1 for 5 cycles -> wr=0, gnt_valid=1 throughout; tx_full drops -> one wr with ack, then IDLE.
REQ-035 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT=4, owner drops req after one byte -> timeout_err pulses after 4 idle cycles, gnt_valid falls, no extra wr.
REQ-036 rst=1 in the 2nd byte of a packet -> next cycle wr=0, ack=0, gnt_valid=0; next grant goes to requester 0 if requesting.
REQ-037 en=0 with req=4'b0010 -> no grant; en raised -> gnt_id=1 one cycle later.
